// File: rtl/ws2812_frame_buffer.sv
// Double-buffered pixel store for a WS2812 LED chain.
// The control side fills the back bank. The serialiser reads the front bank
// through a two-stage pipeline that applies brightness scaling and colour-order
// remapping. Bank exchange happens only at a frame boundary, so a displayed
// frame is never torn.
//
// Handshake semantics: every strobe here is a single-cycle, no-backpressure
// pulse. wr_en and rd_req are accepted on any cycle they are high.
// rd_valid/rd_err/wr_err/rd_data are qualified pulses with no ready.
// swap_req is latched into swap_pending until rd_frame_end executes it.
// The swap FSM state is visible on swap_pending (IDLE=0, PENDING=1).
module ws2812_frame_buffer #(
   parameter int NUM_LEDS = 1000,
   parameter int ADDR_W   = 10,
   parameter int CH_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [3*CH_W-1:0] wr_data,
   output logic              wr_err,
   input  logic              swap_req,
   output logic              swap_pending,
   output logic              front_bank,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_frame_end,
   input  logic [7:0]        brightness,
   input  logic              grb_order,
   output logic [3*CH_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_err
);

   localparam int PIX_W = 3 * CH_W;
   // Pixel count widened by one bit so the range check never overflows.
   localparam logic [ADDR_W:0] LED_COUNT = (ADDR_W+1)'(NUM_LEDS);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } swap_state_t;

   swap_state_t state_q, state_d;
   logic        front_q, front_d;
   logic        do_swap;

   // Two independent banks; contents survive reset on purpose.
   logic [PIX_W-1:0] bank0 [NUM_LEDS];
   logic [PIX_W-1:0] bank1 [NUM_LEDS];

   logic wr_in_range;
   logic rd_in_range;

   // Stage 1 registers: raw pixel plus qualifiers.
   logic             s1_valid;
   logic             s1_err;
   logic [PIX_W-1:0] s1_pix;

   // Stage 2 combinational shaping results.
   logic [CH_W-1:0]  sc_r, sc_g, sc_b;
   logic [PIX_W-1:0] shaped;

   // Scale one channel by (brightness+1)/256.
   // ch*(br+1) is formed as ch*br + ch so no 9-bit increment is needed.
   function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                input logic [7:0]      br);
      logic [CH_W+8:0] prod;
      prod = (CH_W+9)'(ch) * (CH_W+9)'(br) + (CH_W+9)'(ch);
      return prod[CH_W+7:8];
   endfunction

   assign wr_in_range  = ({1'b0, wr_addr} < LED_COUNT);
   assign rd_in_range  = ({1'b0, rd_addr} < LED_COUNT);
   assign front_bank   = front_q;
   assign swap_pending = (state_q == S_PENDING);

   // Swap FSM state register and displayed-bank index.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         front_q <= 1'b0;
      end else begin
         state_q <= state_d;
         front_q <= front_d;
      end
   end

   // Swap FSM next state: a frame end executes any outstanding or simultaneous request.
   always_comb begin
      state_d = state_q;
      front_d = front_q;
      do_swap = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (swap_req && rd_frame_end) begin
               do_swap = 1'b1;
            end else if (swap_req) begin
               state_d = S_PENDING;
            end
         end
         S_PENDING: begin
            if (rd_frame_end) begin
               do_swap = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (do_swap) begin
         front_d = ~front_q;
      end
   end

   // Back-bank write port; uses the bank index as it stands before this edge.
   always_ff @(posedge clk) begin
      if (!rst && wr_en && wr_in_range) begin
         if (front_q) begin
            bank0[wr_addr] <= wr_data;
         end else begin
            bank1[wr_addr] <= wr_data;
         end
      end
   end

   // Out-of-range write flag, one cycle after the dropped write.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_err <= 1'b0;
      end else begin
         wr_err <= wr_en & ~wr_in_range;
      end
   end

   // Stage 1 data: front-bank read, out-of-range addresses never index the array.
   always_ff @(posedge clk) begin
      if (rd_req) begin
         if (!rd_in_range) begin
            s1_pix <= '0;
         end else if (front_q) begin
            s1_pix <= bank1[rd_addr];
         end else begin
            s1_pix <= bank0[rd_addr];
         end
      end
   end

   // Stage 1 qualifiers; reset drops anything in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
      end else begin
         s1_valid <= rd_req;
         s1_err   <= ~rd_in_range;
      end
   end

   // Stage 2 shaping: scale each channel, then pick the wire order.
   always_comb begin
      sc_r = scale_ch(s1_pix[3*CH_W-1:2*CH_W], brightness);
      sc_g = scale_ch(s1_pix[2*CH_W-1:CH_W],   brightness);
      sc_b = scale_ch(s1_pix[CH_W-1:0],        brightness);
      if (grb_order) begin
         shaped = {sc_g, sc_r, sc_b};
      end else begin
         shaped = {sc_r, sc_g, sc_b};
      end
   end

   // Stage 2 output register; rd_data holds its last value between valids.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_valid <= s1_valid;
         rd_err   <= s1_valid & s1_err;
         if (s1_valid) begin
            rd_data <= s1_err ? '0 : shaped;
         end
      end
   end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Bench for ws2812_frame_buffer: reset, table vectors, swap/reset corner
// sequences and a randomized run against a bank-array reference model.
module tb_ws2812_frame_buffer;

   localparam int NUM_LEDS = 1000;
   localparam int ADDR_W   = 10;
   localparam int CH_W     = 8;
   localparam int PIX_W    = 3 * CH_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIX_W-1:0]  wr_data;
   logic              wr_err;
   logic              swap_req;
   logic              swap_pending;
   logic              front_bank;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_frame_end;
   logic [7:0]        brightness;
   logic              grb_order;
   logic [PIX_W-1:0]  rd_data;
   logic              rd_valid;
   logic              rd_err;

   ws2812_frame_buffer #(
      .NUM_LEDS(NUM_LEDS),
      .ADDR_W  (ADDR_W),
      .CH_W    (CH_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_err      (wr_err),
      .swap_req    (swap_req),
      .swap_pending(swap_pending),
      .front_bank  (front_bank),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .rd_frame_end(rd_frame_end),
      .brightness  (brightness),
      .grb_order   (grb_order),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_err      (rd_err)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [PIX_W-1:0] m_bank  [2][NUM_LEDS];
   bit               m_known [2][NUM_LEDS];
   int               m_front;
   int               m_pending;
   // scoreboard: {known, err, raw pixel} and the cycle it must emerge
   logic [PIX_W+1:0] exp_q[$];
   int               due_q[$];
   // observed {rd_err, rd_data} on every valid
   logic [PIX_W:0]   got_q[$];

   int cycle_n = 0;
   int checks  = 0;
   int errors  = 0;

   function automatic logic [PIX_W-1:0] ref_pixel(input logic [PIX_W-1:0] p,
                                                  input int br, input bit grb);
      int r, g, b;
      r = (int'(p[23:16]) * (br + 1)) / 256;
      g = (int'(p[15:8])  * (br + 1)) / 256;
      b = (int'(p[7:0])   * (br + 1)) / 256;
      if (grb) return {g[7:0], r[7:0], b[7:0]};
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycle_n, act, exp);
      end
   endtask

   // One clock: snapshot inputs, advance model at the edge, compare at negedge.
   task automatic tick();
      bit               s_rst, s_wr, s_sr, s_rd, s_fe, s_grb;
      logic [ADDR_W-1:0] s_wa, s_ra;
      logic [PIX_W-1:0] s_wd;
      int               s_br;
      bit               e_valid, e_err, e_known, e_wr_err;
      logic [PIX_W-1:0] e_data;
      logic [PIX_W+1:0] ent;
      s_rst = rst; s_wr = wr_en; s_sr = swap_req; s_rd = rd_req; s_fe = rd_frame_end;
      s_grb = grb_order; s_wa = wr_addr; s_ra = rd_addr; s_wd = wr_data; s_br = int'(brightness);
      e_valid = 0; e_err = 0; e_known = 0; e_wr_err = 0; e_data = '0;
      @(posedge clk);
      cycle_n++;
      if (s_rst) begin
         m_front = 0;
         m_pending = 0;
         exp_q.delete();
         due_q.delete();
      end else begin
         if (due_q.size() > 0 && due_q[0] == cycle_n) begin
            ent = exp_q.pop_front();
            void'(due_q.pop_front());
            e_valid = 1;
            e_known = ent[PIX_W+1];
            e_err   = ent[PIX_W];
            e_data  = e_err ? '0 : ref_pixel(ent[PIX_W-1:0], s_br, s_grb);
         end
         if (s_rd) begin
            if (int'(s_ra) >= NUM_LEDS)
               exp_q.push_back({1'b1, 1'b1, {PIX_W{1'b0}}});
            else
               exp_q.push_back({m_known[m_front][s_ra], 1'b0, m_bank[m_front][s_ra]});
            due_q.push_back(cycle_n + 1);
         end
         if (s_wr && int'(s_wa) < NUM_LEDS) begin
            m_bank[1 - m_front][s_wa]  = s_wd;
            m_known[1 - m_front][s_wa] = 1;
         end
         e_wr_err = s_wr && int'(s_wa) >= NUM_LEDS;
         if (s_fe && (s_sr || m_pending != 0)) begin
            m_front   = 1 - m_front;
            m_pending = 0;
         end else if (s_sr) begin
            m_pending = 1;
         end
      end
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'(e_valid));
      chk("rd_err", 32'(rd_err), 32'(e_err));
      if (e_valid && e_known) chk("rd_data", 32'(rd_data), 32'(e_data));
      if (s_rst) chk("rd_data_rst", 32'(rd_data), 32'h0);
      chk("wr_err", 32'(wr_err), 32'(e_wr_err));
      chk("swap_pending", 32'(swap_pending), 32'(m_pending));
      chk("front_bank", 32'(front_bank), 32'(m_front));
      if (rd_valid) got_q.push_back({rd_err, rd_data});
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_strobes();
      rst = 0; wr_en = 0; swap_req = 0; rd_req = 0; rd_frame_end = 0;
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
      wr_en = 1; wr_addr = a; wr_data = d;
      tick();
      clear_strobes();
   endtask

   task automatic do_swap_now();
      swap_req = 1; rd_frame_end = 1;
      tick();
      clear_strobes();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [PIX_W-1:0]  pix;
      bit                do_wr;
      logic [7:0]        br;
      bit                grb;
      logic [PIX_W-1:0]  exp_data;
      bit                exp_err;
   } vec_t;

   vec_t vecs[8];

   initial begin
      int f0;
      vecs[0] = '{10'd5,    24'hFF8040, 1'b1, 8'd255, 1'b0, 24'hFF8040, 1'b0};
      vecs[1] = '{10'd5,    24'hFF8040, 1'b1, 8'd255, 1'b1, 24'h80FF40, 1'b0};
      vecs[2] = '{10'd5,    24'hFF8040, 1'b1, 8'd127, 1'b0, 24'h7F4020, 1'b0};
      vecs[3] = '{10'd5,    24'hFF8040, 1'b1, 8'd0,   1'b0, 24'h000000, 1'b0};
      vecs[4] = '{10'd999,  24'h123456, 1'b1, 8'd255, 1'b1, 24'h341256, 1'b0};
      vecs[5] = '{10'd0,    24'hFFFFFF, 1'b1, 8'd128, 1'b0, 24'h808080, 1'b0};
      vecs[6] = '{10'd1023, 24'h000000, 1'b0, 8'd255, 1'b0, 24'h000000, 1'b1};
      vecs[7] = '{10'd998,  24'h0A1428, 1'b1, 8'd63,  1'b1, 24'h05020A, 1'b0};

      // ---- reset ----
      clear_strobes();
      wr_addr = '0; wr_data = '0; rd_addr = '0; brightness = 8'd255; grb_order = 0;
      m_front = 0; m_pending = 0;
      rst = 1;
      tick();
      tick();
      clear_strobes();
      idle(1);

      // ---- table vectors: write back bank, swap, read ----
      for (int v = 0; v < 8; v++) begin
         if (vecs[v].do_wr) do_write(vecs[v].addr, vecs[v].pix);
         do_swap_now();
         brightness = vecs[v].br; grb_order = vecs[v].grb;
         got_q.delete();
         rd_req = 1; rd_addr = vecs[v].addr;
         tick();
         clear_strobes();
         tick();
         chk("tbl_valid_count", 32'(got_q.size()), 32'd1);
         if (got_q.size() > 0) begin
            chk("tbl_data", 32'(got_q[0][PIX_W-1:0]), 32'(vecs[v].exp_data));
            chk("tbl_err", 32'(got_q[0][PIX_W]), 32'(vecs[v].exp_err));
         end
      end
      brightness = 8'd255; grb_order = 0;

      // ---- dropped write: wr_err pulse for one cycle only ----
      do_write(10'd1000, 24'hABCDEF);
      tick();

      // ---- brightness is taken in stage 2, not at request time ----
      do_write(10'd7, 24'h808080);
      do_swap_now();
      got_q.delete();
      rd_req = 1; rd_addr = 10'd7;
      tick();
      clear_strobes();
      brightness = 8'd0;
      tick();
      chk("late_br_count", 32'(got_q.size()), 32'd1);
      if (got_q.size() > 0) chk("late_br_data", 32'(got_q[0][PIX_W-1:0]), 32'h0);
      brightness = 8'd255;

      // ---- swap during a read burst: old data through the swap cycle ----
      for (int i = 0; i < 6; i++) do_write(10'(100 + i), 24'h100000 + 24'(i));
      do_swap_now();
      for (int i = 0; i < 6; i++) do_write(10'(100 + i), 24'h200000 + 24'(i));
      swap_req = 1;
      tick();
      clear_strobes();
      idle(7);
      chk("pend_before_end", 32'(swap_pending), 32'd1);
      got_q.delete();
      for (int i = 0; i < 6; i++) begin
         rd_req = 1; rd_addr = 10'(100 + i); rd_frame_end = (i == 2);
         tick();
      end
      clear_strobes();
      idle(2);
      chk("burst_count", 32'(got_q.size()), 32'd6);
      for (int i = 0; i < 6 && i < got_q.size(); i++)
         chk("burst_data", 32'(got_q[i][PIX_W-1:0]),
             (i < 3) ? 32'h100000 + 32'(i) : 32'h200000 + 32'(i));

      // ---- two requests before one frame end: exactly one toggle ----
      f0 = int'(front_bank);
      swap_req = 1; tick(); clear_strobes(); tick();
      swap_req = 1; tick(); clear_strobes(); tick();
      rd_frame_end = 1; tick(); clear_strobes(); tick();
      chk("double_req_toggle", 32'(front_bank), 32'(1 - f0));
      rd_frame_end = 1; tick(); clear_strobes(); tick();
      chk("idle_frame_end", 32'(front_bank), 32'(1 - f0));

      // ---- reset with a read in flight ----
      got_q.delete();
      rd_req = 1; rd_addr = 10'd5;
      tick();
      clear_strobes();
      rst = 1;
      tick();
      clear_strobes();
      tick();
      chk("flight_killed", 32'(got_q.size()), 32'd0);
      chk("front_after_rst", 32'(front_bank), 32'd0);
      // memory survives reset: read both banks back
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 6; i++) begin
            rd_req = 1; rd_addr = 10'(100 + i);
            tick();
         end
         clear_strobes();
         idle(2);
         do_swap_now();
      end

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         wr_en        = ($urandom_range(0, 2) == 0);
         wr_addr      = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(990, 1023))
                                                    : 10'($urandom_range(0, 63));
         wr_data      = 24'($urandom);
         rd_req       = ($urandom_range(0, 1) == 0);
         rd_addr      = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(990, 1023))
                                                     : 10'($urandom_range(0, 63));
         swap_req     = ($urandom_range(0, 19) == 0);
         rd_frame_end = ($urandom_range(0, 29) == 0);
         brightness   = 8'($urandom);
         grb_order    = 1'($urandom);
         tick();
      end
      clear_strobes();
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
